cache_l1_line_fill: RTL and testbench
=====================================

// Module: cache_l1_line_fill
// PURPOSE
//   Parametrised direct-mapped L1 cache with multi-word lines, sitting between the CPU memory stage and main memory.
//   Read misses refill a whole line with sequential single-word memory reads. Writes are write-through and no-write-allocate;
//   a write hit also updates the cached word. Adds an uncached address window, a single-cycle flush and asynchronous reset.
// PARAMETERS
//   ADDR_WIDTH   32  byte-address width
//   DATA_WIDTH   32  word width; power of two, >= 8; BO = $clog2(DATA_WIDTH/8) byte-offset bits
//   INDEX_BITS    5  log2(number of lines)
//   OFFSET_BITS   2  log2(words per line); 0 = one-word lines
//   TAG_BITS     ADDR_WIDTH-BO-OFFSET_BITS-INDEX_BITS (local, derived)
//   Address split: word = addr[BO +: OFFSET_BITS], index = next INDEX_BITS, tag = remaining upper bits
// PORTS
//   clk                in   1           clock; all state updates on the rising edge
//   reset              in   1           asynchronous, active-high
//   address            in   ADDR_WIDTH  CPU byte address; low BO bits ignored
//   readEnable         in   1           CPU read request; held until cacheReady
//   writeEnable        in   1           CPU write request; held until cacheReady
//   dataIn             in   DATA_WIDTH  CPU write data
//   flush              in   1           invalidate every line; sampled only in IDLE
//   dataOut            out  DATA_WIDTH  read data; valid only while cacheReady=1, else 0
//   cacheReady         out  1           one-cycle completion pulse
//   memoryDataIn       in   DATA_WIDTH  memory read data; valid with memoryReady
//   memoryDataOut      out  DATA_WIDTH  equal to dataIn at all times
//   memoryAddress      out  ADDR_WIDTH  FILL: {tag,index,fillCount,BO'b0}; otherwise address
//   memoryReadEnable   out  1           high throughout FILL and UNCACHED_READ
//   memoryWriteEnable  out  1           high throughout WRITE
//   memoryReady        in   1           memory completes the current word access
// BEHAVIOUR
//   Reset, asynchronous: all valid bits 0, state IDLE, fillCount 0, cacheReady/mem enables 0, dataOut 0. Tags/data are not reset.
//   Reset mid-operation aborts the access. Memory enables drop at once, partially filled lines stay invalid, and no cacheReady is issued.
//   Enables are decoded from the registered state. cacheReady = (state==RESPOND) | hitNow.
//   hitNow = IDLE & readEnable & !uncached & valid[idx] & tag match. uncached = address[ADDR_WIDTH-1].
//   IDLE priority: flush > read > write.
//     flush: clear all valid bits at this edge; no cacheReady; stay IDLE; a request in the same cycle is served next cycle.
//     Read hit: cacheReady and dataOut in the same cycle (zero latency); stay IDLE.
//     Read, uncached -> UNCACHED_READ. Read miss -> FILL with fillCount=0.
//     Write (cached or uncached) -> WRITE.
//   FILL: on each memoryReady, store memoryDataIn in line word fillCount and increment.
//     On the last word (fillCount = 2^OFFSET_BITS-1), write tag, set valid, reset fillCount and go to RESPOND.
//     Without memoryReady, hold.
//   UNCACHED_READ: on memoryReady, capture memoryDataIn into a hold register and go to RESPOND. The cache is untouched.
//   WRITE: on memoryReady, if cached and hit, write dataIn into that word; a miss allocates nothing. Go to RESPOND.
//   RESPOND: cacheReady=1 for exactly one cycle. dataOut = requested word (line data, or hold register for uncached).
//     Always returns to IDLE. The CPU must drop or change its request the cycle after cacheReady.
//   Simultaneous readEnable & writeEnable: treated as a read.
//   Evicting a line needs no write-back (write-through). Miss latency = 2^OFFSET_BITS memory words + 1 RESPOND cycle.
// TESTING (INDEX_BITS=5, OFFSET_BITS=2, memory returns word=address, memoryReady 1 cycle after enable)
//   Read 0x104 after reset -> reads at 0x100,0x104,0x108,0x10C; RESPOND dataOut=0x104; then read 0x108 -> same-cycle cacheReady, no memory access.
//   Write 0x104=0xDEADBEEF after fill -> one memory write to 0x104; next read 0x104 -> hit, dataOut=0xDEADBEEF.
//   Write miss 0x2000 -> one memory write, no fill; next read 0x2000 -> miss, 4-word fill from 0x2000.
//   Read 0x100, then 0x300 (same index 16, different tag) -> refill evicts; read 0x100 again -> miss, refill.
//   Read 0x80000010 twice -> each does one memory read at 0x80000010 and no fill.
//   Reset after 2 fill words -> enables 0 at once; line 16 invalid; flush after a fill -> following read of that line misses.

Source files
------------

// File: rtl/cache_l1_line_fill.sv
// Direct-mapped write-through L1 cache with multi-word lines, sequential line refill,
// an uncached window at the top half of the address space, and single-cycle flush.
module cache_l1_line_fill #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  readEnable,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  cacheReady,
    input  logic [DATA_WIDTH-1:0] memoryDataIn,
    output logic [DATA_WIDTH-1:0] memoryDataOut,
    output logic [ADDR_WIDTH-1:0] memoryAddress,
    output logic                  memoryReadEnable,
    output logic                  memoryWriteEnable,
    input  logic                  memoryReady
);

    localparam int BO       = $clog2(DATA_WIDTH / 8);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - BO - OFFSET_BITS - INDEX_BITS;
    localparam int CNT_W    = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
    localparam int SLOT_W   = INDEX_BITS + OFFSET_BITS;
    localparam int LINE_SH  = BO + OFFSET_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_UNCACHED_READ,
        S_WRITE,
        S_RESPOND
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      fill_cnt_q;
    logic [LINES-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] hold_q;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES*WORDS];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [SLOT_W-1:0]     req_slot;
    logic [SLOT_W-1:0]     fill_slot;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  uncached;
    logic                  tag_hit;
    logic                  hit_now;
    logic                  fill_last;

    // A data-array slot is {index, word}, i.e. the address bits just above the byte offset.
    assign req_index = INDEX_BITS'(address >> LINE_SH);
    assign req_tag   = TAG_BITS'(address >> (LINE_SH + INDEX_BITS));
    assign req_slot  = SLOT_W'(address >> BO);
    assign fill_slot = (SLOT_W'(req_index) << OFFSET_BITS) | SLOT_W'(fill_cnt_q);
    assign fill_addr = ((address >> LINE_SH) << LINE_SH) | (ADDR_WIDTH'(fill_cnt_q) << BO);
    assign fill_last = (fill_cnt_q == CNT_W'(WORDS - 1));

    assign uncached = address[ADDR_WIDTH-1];
    assign tag_hit  = valid_q[req_index] && (tag_mem[req_index] == req_tag);
    // A flush in the same cycle wins, so the read must not complete as a hit.
    assign hit_now  = (state_q == S_IDLE) && !flush && readEnable && !uncached && tag_hit;

    assign cacheReady        = (state_q == S_RESPOND) || hit_now;
    assign memoryReadEnable  = (state_q == S_FILL) || (state_q == S_UNCACHED_READ);
    assign memoryWriteEnable = (state_q == S_WRITE);
    assign memoryDataOut     = dataIn;
    assign memoryAddress     = (state_q == S_FILL) ? fill_addr : address;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        dataOut = '0;
        if (hit_now) begin
            dataOut = data_mem[req_slot];
        end else if (state_q == S_RESPOND) begin
            dataOut = uncached ? hold_q : data_mem[req_slot];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            valid_q    <= '0;
            hold_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (readEnable) begin
                        if (uncached) begin
                            state_q <= S_UNCACHED_READ;
                        end else if (!tag_hit) begin
                            fill_cnt_q <= '0;
                            state_q    <= S_FILL;
                        end
                    end else if (writeEnable) begin
                        state_q <= S_WRITE;
                    end
                end
                S_FILL: begin
                    if (memoryReady) begin
                        if (fill_last) begin
                            valid_q[req_index] <= 1'b1;
                            fill_cnt_q         <= '0;
                            state_q            <= S_RESPOND;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_UNCACHED_READ: begin
                    if (memoryReady) begin
                        hold_q  <= memoryDataIn;
                        state_q <= S_RESPOND;
                    end
                end
                S_WRITE: begin
                    if (memoryReady) begin
                        state_q <= S_RESPOND;
                    end
                end
                S_RESPOND: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && memoryReady) begin
            data_mem[fill_slot] <= memoryDataIn;
            if (fill_last) begin
                tag_mem[req_index] <= req_tag;
            end
        end
        if (state_q == S_WRITE && memoryReady && !uncached && tag_hit) begin
            data_mem[req_slot] <= dataIn;
        end
    end

endmodule

// File: tb/tb_cache_l1_line_fill.sv
// Scoreboard bench for cache_l1_line_fill: a memory model returns word = address, a line-level
// reference model predicts every response, and a monitor compares responses and memory traffic.
module tb_cache_l1_line_fill;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address;
    logic        readEnable;
    logic        writeEnable;
    logic [31:0] dataIn;
    logic        flush;
    logic [31:0] dataOut;
    logic        cacheReady;
    logic [31:0] memoryDataIn = '0;
    logic [31:0] memoryDataOut;
    logic [31:0] memoryAddress;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic        memoryReady = 1'b0;

    always #5 clk = ~clk;

    cache_l1_line_fill dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .readEnable        (readEnable),
        .writeEnable       (writeEnable),
        .dataIn            (dataIn),
        .flush             (flush),
        .dataOut           (dataOut),
        .cacheReady        (cacheReady),
        .memoryDataIn      (memoryDataIn),
        .memoryDataOut     (memoryDataOut),
        .memoryAddress     (memoryAddress),
        .memoryReadEnable  (memoryReadEnable),
        .memoryWriteEnable (memoryWriteEnable),
        .memoryReady       (memoryReady)
    );

    typedef struct {
        bit              is_read;
        bit              hit;
        logic [31:0]     data;
        int              n_rd;
        logic [3:0][31:0] rd_addr;
        int              n_wr;
        logic [31:0]     wr_addr;
        logic [31:0]     wr_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [63:0] wr_q[$];
    int          tests = 0;
    int          fails = 0;
    int          wait_cnt = 0;

    // Reference model: 32 lines x 4 words, tag = addr[31:9], index = addr[8:4], word = addr[3:2].
    bit          m_valid [32];
    logic [31:0] m_tag   [32];
    logic [31:0] m_data  [32][4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_read(input logic [31:0] a, output exp_t e);
        int idx = int'((a >> 4) & 32'h1F);
        int w   = int'((a >> 2) & 32'h3);
        e = '{default: '0};
        e.is_read = 1'b1;
        if (a[31]) begin
            e.data       = a;
            e.n_rd       = 1;
            e.rd_addr[0] = a;
        end else if (m_valid[idx] && m_tag[idx] == (a >> 9)) begin
            e.hit  = 1'b1;
            e.data = m_data[idx][w];
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_data[idx][i] = (a & ~32'hF) + 32'(4 * i);
                e.rd_addr[i]   = m_data[idx][i];
            end
            e.n_rd       = 4;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a >> 9;
            e.data       = m_data[idx][w];
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, output exp_t e);
        int idx = int'((a >> 4) & 32'h1F);
        int w   = int'((a >> 2) & 32'h3);
        e = '{default: '0};
        e.n_wr    = 1;
        e.wr_addr = a;
        e.wr_data = d;
        if (!a[31] && m_valid[idx] && m_tag[idx] == (a >> 9)) m_data[idx][w] = d;
    endtask

    // Memory: word = address, ready one or more cycles after an enable is seen.
    always @(negedge clk) begin
        if (reset) begin
            memoryReady  = 1'b0;
            memoryDataIn = '0;
        end else if ((memoryReadEnable || memoryWriteEnable) && !memoryReady
                     && ($urandom_range(0, 3) != 0)) begin
            memoryReady  = 1'b1;
            memoryDataIn = memoryAddress;
        end else begin
            memoryReady  = 1'b0;
            memoryDataIn = $urandom;
        end
    end

    always @(posedge clk) begin
        if (!reset && memoryReady) begin
            if (memoryReadEnable)  rd_q.push_back(memoryAddress);
            if (memoryWriteEnable) wr_q.push_back({memoryAddress, memoryDataOut});
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            wait_cnt = 0;
        end else if (cacheReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cacheReady", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read) check("read_data", dataOut, mon_e.data);
                if (mon_e.hit) check("hit_latency", 32'(wait_cnt), 32'd0);
                check("mem_read_count", 32'(rd_q.size()), 32'(mon_e.n_rd));
                for (int i = 0; i < 4; i++)
                    if (i < mon_e.n_rd && i < rd_q.size())
                        check("mem_read_addr", rd_q[i], mon_e.rd_addr[i]);
                check("mem_write_count", 32'(wr_q.size()), 32'(mon_e.n_wr));
                if (mon_e.n_wr > 0 && wr_q.size() > 0) begin
                    check("mem_write_addr", wr_q[0][63:32], mon_e.wr_addr);
                    check("mem_write_data", wr_q[0][31:0], mon_e.wr_data);
                end
            end
            rd_q.delete();
            wr_q.delete();
            wait_cnt = 0;
        end else begin
            if (readEnable || writeEnable) wait_cnt++;
            check("dataOut_idle_zero", dataOut, 32'd0);
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        flush       = 1'b0;
        model_clear();
        exp_q.delete();
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (cacheReady) seen = 1'b1;
        end
        if (!seen) begin
            check("ready_timeout", 32'd0, 32'd1);
            do_reset();
        end
    endtask

    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        if (rd) model_read(a, e);
        else    model_write(a, d, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        address     = a;
        dataIn      = d;
        readEnable  = rd;
        writeEnable = wr;
        flush       = 1'b0;
        wait_ready();
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        flush       = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic flush_with_read(input logic [31:0] a);
        exp_t e;
        model_clear();
        model_read(a, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        address     = a;
        readEnable  = 1'b1;
        writeEnable = 1'b0;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_ready();
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        @(posedge clk);
        #1;
        address     = a;
        readEnable  = 1'b1;
        writeEnable = 1'b0;
        for (int i = 0; i < 100 && rd_q.size() < 2; i++) @(negedge clk);
        check("fill_words_before_reset", 32'(rd_q.size()), 32'd2);
        reset = 1'b1;
        #1;
        check("reset_mem_read_en", 32'(memoryReadEnable), 32'd0);
        check("reset_mem_write_en", 32'(memoryWriteEnable), 32'd0);
        check("reset_cacheReady", 32'(cacheReady), 32'd0);
        do_reset();
    endtask

    logic [31:0] ra;
    int          op;

    initial begin
        address     = '0;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        dataIn      = '0;
        flush       = 1'b0;
        #12;
        check("reset_cacheReady", 32'(cacheReady), 32'd0);
        check("reset_mem_read_en", 32'(memoryReadEnable), 32'd0);
        check("reset_mem_write_en", 32'(memoryWriteEnable), 32'd0);
        check("reset_dataOut", dataOut, 32'd0);
        do_reset();

        run_txn(1, 0, 32'h0000_0104, 32'h0);           // miss, 4-word fill
        run_txn(1, 0, 32'h0000_0108, 32'h0);           // hit, same cycle
        run_txn(0, 1, 32'h0000_0104, 32'hDEAD_BEEF);   // write hit
        run_txn(1, 0, 32'h0000_0104, 32'h0);
        run_txn(0, 1, 32'h0000_2000, 32'h1234_5678);   // write miss, no allocate
        run_txn(1, 0, 32'h0000_2000, 32'h0);
        run_txn(1, 0, 32'h0000_0100, 32'h0);
        run_txn(1, 0, 32'h0000_0300, 32'h0);           // same index, evicts
        run_txn(1, 0, 32'h0000_0100, 32'h0);
        idle();
        run_txn(1, 0, 32'h8000_0010, 32'h0);           // uncached
        idle();
        run_txn(1, 0, 32'h8000_0010, 32'h0);
        run_txn(1, 1, 32'h0000_010C, 32'hCAFE_F00D);   // both enables: a read
        idle();
        do_flush();
        run_txn(1, 0, 32'h0000_0104, 32'h0);           // misses after flush
        idle();
        flush_with_read(32'h0000_0108);
        idle();
        do_flush();
        reset_mid_fill(32'h0000_0100);
        run_txn(1, 0, 32'h0000_0108, 32'h0);           // line 16 still invalid
        idle();

        for (int n = 0; n < 300; n++) begin
            ra = (32'($urandom_range(0, 2)) << 9)
               | (32'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) == 0 ? 16 : 31)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 7) == 0) ra[31] = 1'b1;
            op = int'($urandom_range(0, 19));
            if (op < 12)       run_txn(1, 0, ra, $urandom);
            else if (op < 17)  run_txn(0, 1, ra, $urandom);
            else if (op == 17) run_txn(1, 1, ra, $urandom);
            else if (op == 18) do_flush();
            else               idle();
        end
        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, failed so far %0d", fails);
        $fatal(1, "global timeout");
    end

endmodule
